// File: rtl/vid_sprite_linebuf_ctl.sv
// Ping-pong controller for the 2048x9 sprite line buffer: port A handles the power-up clear
// sweep and the renderer's read-check-write, port B does scanout read-and-clear.
module vid_sprite_linebuf_ctl #(
    parameter int         H_PIXELS  = 480,
    parameter logic [8:0] CLEAR_VAL = 9'h001
) (
    input  logic        ClockA,
    input  logic        ResetB,
    input  logic        line_start,
    input  logic        px_valid,
    output logic        px_ready,
    input  logic [9:0]  px_x,
    input  logic [8:0]  px_data,
    output logic        px_late,
    input  logic        out_req,
    input  logic [9:0]  out_x,
    output logic        out_valid,
    output logic [8:0]  out_data,
    output logic        init_busy,
    output logic [10:0] lb_addr_a,
    output logic [8:0]  lb_din_a,
    output logic        lb_en_a,
    output logic        lb_we_a,
    input  logic [8:0]  lb_qa,
    output logic [10:0] lb_addr_b,
    output logic [8:0]  lb_din_b,
    output logic        lb_en_b,
    output logic        lb_we_b,
    input  logic [8:0]  lb_qb
);

    localparam logic [9:0] X_LIMIT = 10'(H_PIXELS);

    typedef enum logic [1:0] {SWEEP, IDLE, READ, CHECK} stateT;

    stateT       stateReg;
    logic        frontReg;
    logic        frontNext;
    logic [10:0] sweepCnt;
    logic [9:0]  pxXReg;
    logic [8:0]  pxDataReg;
    logic        pxHalfReg;

    assign frontNext = line_start ? ~frontReg : frontReg;

    // Port A outputs are registered from the next state, so the RAM sees them in that state.
    always_ff @(posedge ClockA) begin
        if (ResetB) begin
            stateReg  <= SWEEP;
            frontReg  <= 1'b0;
            sweepCnt  <= '0;
            pxXReg    <= '0;
            pxDataReg <= '0;
            pxHalfReg <= 1'b0;
            init_busy <= 1'b1;
            px_ready  <= 1'b0;
            px_late   <= 1'b0;
            lb_en_a   <= 1'b0;
            lb_we_a   <= 1'b0;
            lb_addr_a <= '0;
            lb_din_a  <= '0;
        end else begin
            frontReg <= frontNext;
            lb_en_a  <= 1'b0;
            lb_we_a  <= 1'b0;
            px_late  <= 1'b0;
            case (stateReg)
                SWEEP: begin
                    lb_en_a   <= 1'b1;
                    lb_we_a   <= 1'b1;
                    lb_din_a  <= CLEAR_VAL;
                    lb_addr_a <= sweepCnt;
                    sweepCnt  <= sweepCnt + 11'd1;
                    if (sweepCnt == 11'd2047) begin
                        stateReg  <= IDLE;
                        init_busy <= 1'b0;
                        px_ready  <= 1'b1;
                    end
                end
                IDLE: begin
                    if (px_valid) begin
                        pxXReg    <= px_x;
                        pxDataReg <= px_data;
                        pxHalfReg <= ~frontReg;
                        // Off-screen pixels are swallowed without touching the RAM.
                        if (px_x < X_LIMIT) begin
                            stateReg  <= READ;
                            px_ready  <= 1'b0;
                            lb_en_a   <= 1'b1;
                            lb_addr_a <= {~frontReg, px_x};
                        end
                    end
                end
                READ: begin
                    stateReg <= CHECK;
                end
                CHECK: begin
                    stateReg <= IDLE;
                    px_ready <= 1'b1;
                    // Compare against the post-edge front so a swap in this very cycle also discards.
                    if (pxHalfReg != ~frontNext) begin
                        px_late <= 1'b1;
                    end else if (lb_qa == CLEAR_VAL) begin
                        lb_en_a   <= 1'b1;
                        lb_we_a   <= 1'b1;
                        lb_addr_a <= {pxHalfReg, pxXReg};
                        lb_din_a  <= pxDataReg;
                    end
                end
                default: stateReg <= SWEEP;
            endcase
        end
    end

    // Scanout reads the old word and clears it in one RAM access.
    assign lb_en_b   = out_req & ~ResetB;
    assign lb_we_b   = out_req & ~ResetB;
    assign lb_din_b  = CLEAR_VAL;
    assign lb_addr_b = {frontReg, out_x};
    assign out_data  = lb_qb;

    always_ff @(posedge ClockA) begin
        if (ResetB) begin
            out_valid <= 1'b0;
        end else begin
            out_valid <= out_req;
        end
    end

endmodule

// File: tb/tb_vid_sprite_linebuf_ctl.sv
// Bench for vid_sprite_linebuf_ctl: behavioural RAM plus a per-line-half pixel model
// driven by directed scenarios and a randomized renderer/scanout mix.
module tb_vid_sprite_linebuf_ctl;

    localparam logic [8:0] CLEAR = 9'h001;

    logic        ClockA = 1'b0;
    logic        ResetB = 1'b1;
    logic        line_start = 1'b0;
    logic        px_valid = 1'b0;
    logic        px_ready;
    logic [9:0]  px_x = '0;
    logic [8:0]  px_data = '0;
    logic        px_late;
    logic        out_req = 1'b0;
    logic [9:0]  out_x = '0;
    logic        out_valid;
    logic [8:0]  out_data;
    logic        init_busy;
    logic [10:0] lb_addr_a, lb_addr_b;
    logic [8:0]  lb_din_a, lb_din_b;
    logic        lb_en_a, lb_we_a, lb_en_b, lb_we_b;
    logic [8:0]  lb_qa, lb_qb;

    always #5 ClockA = ~ClockA;

    vid_sprite_linebuf_ctl dut (
        .ClockA(ClockA), .ResetB(ResetB), .line_start(line_start),
        .px_valid(px_valid), .px_ready(px_ready), .px_x(px_x), .px_data(px_data),
        .px_late(px_late), .out_req(out_req), .out_x(out_x), .out_valid(out_valid),
        .out_data(out_data), .init_busy(init_busy),
        .lb_addr_a(lb_addr_a), .lb_din_a(lb_din_a), .lb_en_a(lb_en_a), .lb_we_a(lb_we_a),
        .lb_qa(lb_qa), .lb_addr_b(lb_addr_b), .lb_din_b(lb_din_b), .lb_en_b(lb_en_b),
        .lb_we_b(lb_we_b), .lb_qb(lb_qb)
    );

    // 2048x9 dual-port RAM, registered reads, port B read-before-write.
    logic [8:0] mem [0:2047];
    logic       ramFill = 1'b0;
    always @(posedge ClockA) begin
        if (ramFill) begin
            for (int i = 0; i < 2048; i++) mem[i] <= 9'($urandom);
        end else begin
            if (lb_en_a) begin
                if (lb_we_a) mem[lb_addr_a] <= lb_din_a;
                else         lb_qa <= mem[lb_addr_a];
            end
            if (lb_en_b) begin
                lb_qb <= mem[lb_addr_b];
                if (lb_we_b) mem[lb_addr_b] <= lb_din_b;
            end
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic checkEq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: contents of each half, plus the one pixel that may be in flight.
    logic [8:0] refBuf [2][1024];
    bit         refFront = 1'b0;
    int         swCount = 0;
    int         pend = 0;
    bit         pxHalf;
    int         pxX;
    logic [8:0] pxData;
    bit         expLate = 1'b0;
    bit         expOutValid = 1'b0;
    logic [8:0] expOutData = '0;
    int         portAEnCnt = 0;
    int         portAWrCnt = 0;
    int         lateCnt = 0;

    task automatic tick();
        bit frontPost;
        bit readyNow;
        @(posedge ClockA);
        if (ResetB) begin
            swCount = 0; pend = 0; refFront = 1'b0; expLate = 1'b0; expOutValid = 1'b0;
        end else begin
            frontPost = line_start ? ~refFront : refFront;
            readyNow  = (swCount >= 2048) && (pend == 0);
            expLate = 1'b0;
            expOutValid = out_req;
            if (out_req) begin
                expOutData = refBuf[refFront][out_x];
                refBuf[refFront][out_x] = CLEAR;
            end
            if (pend > 0) begin
                pend--;
                if (pend == 0) begin
                    if (pxHalf == frontPost) expLate = 1'b1;
                    else if (refBuf[pxHalf][pxX] == CLEAR) refBuf[pxHalf][pxX] = pxData;
                end
            end else if (readyNow && px_valid && px_x < 10'd480) begin
                pend = 2; pxHalf = ~refFront; pxX = int'(px_x); pxData = px_data;
            end
            if (swCount < 2048) begin
                swCount++;
                if (swCount == 2048)
                    for (int h = 0; h < 2; h++) for (int i = 0; i < 1024; i++) refBuf[h][i] = CLEAR;
            end
            refFront = frontPost;
        end
        @(negedge ClockA);
        checkEq("init_busy", init_busy, swCount < 2048);
        checkEq("px_ready", px_ready, (swCount >= 2048) && (pend == 0));
        checkEq("px_late", px_late, expLate);
        checkEq("out_valid", out_valid, expOutValid);
        if (expOutValid) checkEq("out_data", out_data, expOutData);
        portAEnCnt += int'(lb_en_a);
        portAWrCnt += int'(lb_en_a && lb_we_a);
        lateCnt    += int'(px_late);
    endtask

    task automatic sendPx(input logic [9:0] x, input logic [8:0] d);
        int n = 0;
        px_valid = 1'b1; px_x = x; px_data = d;
        while (!px_ready && n < 20) begin tick(); n++; end
        checkEq("px_accept_wait", n < 20, 1);
        tick();
        px_valid = 1'b0;
    endtask

    task automatic lineStart();
        line_start = 1'b1; tick(); line_start = 1'b0;
    endtask

    task automatic scanX(input logic [9:0] x, output logic [8:0] d);
        out_req = 1'b1; out_x = x; tick(); out_req = 1'b0; d = out_data;
    endtask

    task automatic scanHalf(output int nonClear);
        nonClear = 0;
        for (int x = 0; x < 1024; x++) begin
            out_req = 1'b1; out_x = 10'(x); tick();
            if (out_data !== CLEAR) nonClear++;
        end
        out_req = 1'b0; tick();
    endtask

    task automatic sweepRun(input string tag);
        int busyCnt = 0;
        int bad = 0;
        for (int i = 0; i < 2050; i++) begin
            if (init_busy) busyCnt++;
            tick();
            if (i == 0) begin
                checkEq({tag, "_first_addr"}, lb_addr_a, 0);
                checkEq({tag, "_first_en"}, lb_en_a, 1);
            end
        end
        checkEq({tag, "_busy_cycles"}, busyCnt, 2048);
        for (int i = 0; i < 2048; i++) if (mem[i] !== CLEAR) bad++;
        checkEq({tag, "_ram_not_clear"}, bad, 0);
    endtask

    initial begin
        logic [8:0] d;
        int cnt;
        int accCnt;
        int lastAcc;
        ramFill = 1'b1;
        tick();
        ramFill = 1'b0;
        tick(); tick();
        checkEq("reset_px_ready", px_ready, 0);
        checkEq("reset_en_a", lb_en_a, 0);
        ResetB = 1'b0;

        // Power-up sweep over randomized RAM contents.
        sweepRun("sweep");

        // Earlier-drawn pixel wins; scanout clears after reading.
        sendPx(10'd5, 9'h0AA); repeat (3) tick();
        sendPx(10'd5, 9'h055); repeat (3) tick();
        lineStart();
        scanX(10'd5, d); checkEq("t2_first_read", d, 9'h0AA);
        scanX(10'd5, d); checkEq("t2_second_read", d, 9'h001);

        // Off-screen pixel: accepted with no RAM access.
        repeat (2) tick();
        portAEnCnt = 0;
        sendPx(10'd480, 9'h0FF); repeat (4) tick();
        checkEq("t3_porta_accesses", portAEnCnt, 0);
        lineStart();
        scanHalf(cnt); checkEq("t3_nonclear_words", cnt, 0);

        // Swap during CHECK discards the pixel.
        lineStart(); repeat (2) tick();
        sendPx(10'd7, 9'h123);
        portAWrCnt = 0; lateCnt = 0;
        tick();
        lineStart();
        repeat (5) tick();
        checkEq("t4_porta_writes", portAWrCnt, 0);
        checkEq("t4_late_pulses", lateCnt, 1);
        scanX(10'd7, d); checkEq("t4_x7_clear", d, 9'h001);

        // Sustained px_valid: one accept every 3 cycles.
        repeat (3) tick();
        accCnt = 0; lastAcc = -1;
        px_valid = 1'b1;
        for (int c = 0; c < 12; c++) begin
            px_x = 10'($urandom_range(0, 479)); px_data = 9'($urandom);
            if (px_ready) begin
                if (lastAcc >= 0) checkEq("t5_accept_gap", c - lastAcc, 3);
                lastAcc = c; accCnt++;
            end
            tick();
        end
        px_valid = 1'b0;
        checkEq("t5_accepts", accCnt, 4);
        repeat (3) tick();

        // Randomized renderer / scanout / swap mix.
        for (int c = 0; c < 1500; c++) begin
            px_valid = ($urandom_range(0, 1) == 1);
            px_x = 10'($urandom_range(0, 599));
            px_data = 9'($urandom);
            out_req = ($urandom_range(0, 9) < 4);
            out_x = 10'($urandom);
            line_start = !px_valid && ($urandom_range(0, 39) == 0);
            tick();
        end
        px_valid = 1'b0; out_req = 1'b0; line_start = 1'b0;
        repeat (4) tick();
        lineStart(); scanHalf(cnt);
        lineStart(); scanHalf(cnt);

        // Reset in the middle of the sweep restarts it from address 0.
        ResetB = 1'b1; tick(); ResetB = 1'b0;
        repeat (1000) tick();
        ResetB = 1'b1; tick(); ResetB = 1'b0;
        sweepRun("t6_restart");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
